skin_coord_stream: RTL
======================

// Module: skin_coord_stream
// PURPOSE
//   Upstream feeder of the centroid stage. Consumes a raster stream of chroma pixels (Cb, Cr).
//   Tracks the raster position (x, y) of every pixel and classifies each one as skin or not
//   against fixed chroma windows. Emits the (x, y) of each skin pixel with data_enable.
//   Pulses data_end once per frame so the centroid stage can divide.
// PARAMETERS
//   DATA_WIDTH  8    coordinate width; must satisfy 2**DATA_WIDTH >= max(FRAME_W, FRAME_H)
//   CNT_WIDTH   16   width of hit_count
//   FRAME_W     160  pixels per line
//   FRAME_H     120  lines per frame
//   CB_MIN      77   inclusive lower Cb bound for skin
//   CB_MAX      127  inclusive upper Cb bound for skin
//   CR_MIN      133  inclusive lower Cr bound for skin
//   CR_MAX      173  inclusive upper Cr bound for skin
// PORTS
//   clk          in   1           single clock, all logic on rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   pix_valid    in   1           pix_cb/pix_cr/pix_sof are valid this cycle
//   pix_sof      in   1           qualifies pix_valid: this pixel is (0,0) of a new frame
//   pix_cb       in   8           Cb chroma, unsigned
//   pix_cr       in   8           Cr chroma, unsigned
//   data_out_x   out  DATA_WIDTH  x of the skin pixel (valid with data_enable)
//   data_out_y   out  DATA_WIDTH  y of the skin pixel (valid with data_enable)
//   data_enable  out  1           one skin coordinate this cycle
//   data_end     out  1           single-cycle pulse: frame finished, no more coordinates
//   hit_count    out  CNT_WIDTH   skin pixels in the last completed frame; saturates at all-ones
//   frame_err    out  1           single-cycle pulse: pix_sof arrived mid-frame
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; x = y = 0; internal hit counter 0.
//   No backpressure: one pixel accepted on every cycle with pix_valid=1.
//   pix_valid=0 gaps hold all counters and state.
//   States:
//     IDLE: pixels without pix_sof are ignored. pix_valid & pix_sof -> SCAN.
//           That pixel is classified as (0,0).
//     SCAN: each valid pixel is classified at the current (x, y), then x++.
//           At x = FRAME_W-1: x wraps to 0 and y++.
//           Last pixel (x = FRAME_W-1, y = FRAME_H-1) is classified normally -> END.
//     END:  one cycle. Pulses data_end, loads hit_count, clears internal counter -> IDLE.
//           A valid pixel arriving in END is ignored, even if it carries pix_sof.
//   Classification: skin = (CB_MIN <= cb <= CB_MAX) && (CR_MIN <= cr <= CR_MAX).
//   Latency: data_enable / data_out_x / data_out_y are registered, 1 cycle after the pixel.
//   data_out_x / data_out_y hold their last value when data_enable=0.
//   data_end rises 2 cycles after the last pixel, so it is always exactly 1 cycle after that
//   pixel's data_enable slot. data_end and data_enable are never high together.
//   Empty frame: data_end still pulses. hit_count = 0; no data_enable in that frame.
//   Early pix_sof in SCAN, with (x, y) != (0,0):
//     - the sof pixel is dropped, not classified
//     - frame_err and data_end pulse 1 cycle later; hit_count loads the partial count
//     - state -> IDLE; the next frame starts at the next pix_sof
//   Internal hit counter saturates; it never wraps.
//   rst_n low mid-frame: immediate return to reset values. No data_end is emitted.
// STRUCTURE
//   Shared package (face_det_pkg):
//     - default FRAME_W/FRAME_H and Cb/Cr bound constants
//     - state encoding constants IDLE / SCAN / END
//   Sub-module skin_classifier: combinational Cb/Cr window compare. Thresholds are parameters.
//   Reused later by the display-overlay stage.
//   Top level holds the x/y raster counters, the FSM, the output register stage and the
//   hit counter.
// TESTING
//   - FRAME_W=4, FRAME_H=2, all pixels cb=100 cr=150:
//     -> 8 data_enable pulses, coordinates (0,0)..(3,1) in raster order
//     -> data_end 1 cycle after the last one; hit_count=8
//   - Same frame, only pixel (2,1) skin:
//     -> single data_enable with x=2, y=1; hit_count=1
//   - Boundaries cb=77/127 and cr=133/173 are skin; cb=76/128 and cr=132/174 are not.
//     Check every combination.
//   - pix_valid toggling 1-0-1 through the frame
//     -> identical coordinate sequence to the gap-free run; data_end 2 cycles after last pixel
//   - pix_sof at pixel (1,0) after skin pixel (0,0):
//     -> frame_err and data_end pulse together; hit_count=1
//     -> further pixels ignored until the next pix_sof
//   - rst_n asserted mid-frame, async:
//     -> outputs 0 at once, no data_end
//     -> next pix_sof frame is reported correctly; all-non-skin frame gives data_end with hit_count=0

Source files
------------

// File: rtl/face_det_pkg.sv
// Shared constants and state encoding for the face-detection pipeline.
// Default frame geometry and skin chroma windows live here so every stage agrees.
package face_det_pkg;

  localparam int FRAME_W_DEF = 160;
  localparam int FRAME_H_DEF = 120;

  localparam logic [7:0] CB_MIN_DEF = 8'd77;
  localparam logic [7:0] CB_MAX_DEF = 8'd127;
  localparam logic [7:0] CR_MIN_DEF = 8'd133;
  localparam logic [7:0] CR_MAX_DEF = 8'd173;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    END  = 2'd2
  } state_e;

endpackage

// File: rtl/skin_classifier.sv
// Combinational skin test: a pixel is skin when both Cb and Cr sit inside
// their inclusive windows. Also used by the display-overlay stage.
module skin_classifier
  import face_det_pkg::*;
#(
  parameter logic [7:0] CB_MIN = CB_MIN_DEF,
  parameter logic [7:0] CB_MAX = CB_MAX_DEF,
  parameter logic [7:0] CR_MIN = CR_MIN_DEF,
  parameter logic [7:0] CR_MAX = CR_MAX_DEF
) (
  input  logic [7:0] cb_i,
  input  logic [7:0] cr_i,
  output logic       skin_o
);

  assign skin_o = (cb_i >= CB_MIN) && (cb_i <= CB_MAX) &&
                  (cr_i >= CR_MIN) && (cr_i <= CR_MAX);

endmodule

// File: rtl/skin_coord_stream.sv
// Tracks raster position of an incoming chroma stream and emits the (x, y) of
// every skin pixel, with an end-of-frame pulse and a per-frame hit count.
module skin_coord_stream
  import face_det_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         CNT_WIDTH  = 16,
  parameter int         FRAME_W    = FRAME_W_DEF,
  parameter int         FRAME_H    = FRAME_H_DEF,
  parameter logic [7:0] CB_MIN     = CB_MIN_DEF,
  parameter logic [7:0] CB_MAX     = CB_MAX_DEF,
  parameter logic [7:0] CR_MIN     = CR_MIN_DEF,
  parameter logic [7:0] CR_MAX     = CR_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [7:0]            pix_cb,
  input  logic [7:0]            pix_cr,
  output logic [DATA_WIDTH-1:0] data_out_x,
  output logic [DATA_WIDTH-1:0] data_out_y,
  output logic                  data_enable,
  output logic                  data_end,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic                  frame_err
);

  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(FRAME_W - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(FRAME_H - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
  logic [DATA_WIDTH-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
  logic                    enable_q, enable_d;
  logic                    end_q, end_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    hit_count_q, hit_count_d;
  logic                    skin;
  logic                    step;

  skin_classifier #(
    .CB_MIN(CB_MIN),
    .CB_MAX(CB_MAX),
    .CR_MIN(CR_MIN),
    .CR_MAX(CR_MAX)
  ) u_classifier (
    .cb_i  (pix_cb),
    .cr_i  (pix_cr),
    .skin_o(skin)
  );

  // step marks a pixel that is classified at (x_q, y_q) and advances the raster.
  // In IDLE the counters are already parked at (0,0), so the sof pixel shares the SCAN path.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    hit_cnt_d   = hit_cnt_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    enable_d    = 1'b0;
    end_d       = 1'b0;
    err_d       = 1'b0;
    hit_count_d = hit_count_q;
    step        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pix_valid && pix_sof) step = 1'b1;
      end
      SCAN: begin
        if (pix_valid) begin
          if (pix_sof && ((x_q != '0) || (y_q != '0))) begin
            err_d       = 1'b1;
            end_d       = 1'b1;
            hit_count_d = hit_cnt_q;
            hit_cnt_d   = '0;
            x_d         = '0;
            y_d         = '0;
            state_d     = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      END: begin
        end_d       = 1'b1;
        hit_count_d = hit_cnt_q;
        hit_cnt_d   = '0;
        x_d         = '0;
        y_d         = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (step) begin
      state_d = SCAN;
      if (skin) begin
        enable_d  = 1'b1;
        out_x_d   = x_q;
        out_y_d   = y_q;
        hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
      end
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) state_d = END;
        else               y_d     = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      hit_cnt_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      enable_q    <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hit_cnt_q   <= hit_cnt_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      enable_q    <= enable_d;
      end_q       <= end_d;
      err_q       <= err_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign data_out_x  = out_x_q;
  assign data_out_y  = out_y_q;
  assign data_enable = enable_q;
  assign data_end    = end_q;
  assign frame_err   = err_q;
  assign hit_count   = hit_count_q;

endmodule
